qspi_mem_arbiter: RTL and testbench

- Shares the single external SPI memory bus between the CPU instruction-fetch port and the load/store data port inside the SoC.
- The bus carries a flash chip-select and a PSRAM chip-select.
- Arbitrates between the two requesters, then sequences one complete SPI transaction (command, 24-bit address, 1/2/4 data bytes) and returns read data.
- Sits between the core and the top-level pin mux, which maps the spi_* signals onto the bidirectional IOs.

---
 rtl/soc_pkg.sv | 42 ++++
 rtl/spi_shifter.sv | 116 +++++++++++
 rtl/qspi_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_qspi_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared SPI memory definitions: command opcodes, transfer size encodings,
// arbiter FSM states and byte-order helpers.
package soc_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_WALT = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic  is_fetch;
    size_e size;
  } xfer_ctx_t;

  // Command + 24 address bits + 8/16/32 data bits.
  function automatic logic [6:0] xfer_bits(input size_e s);
    case (s)
      SIZE_BYTE: return 7'd40;
      SIZE_HALF: return 7'd48;
      default:   return 7'd64;
    endcase
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// Mode-0 SPI bit engine: shifts out a left-aligned word MSB first and
// shifts MISO in, with a start pulse and a combinational done pulse.
module spi_shifter #(
  parameter int SCLK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] tx_word,
  input  logic [6:0]  bit_count,
  input  logic        spi_miso,
  output logic [6:0]  bit_idx,
  output logic        bit_end,
  output logic        done,
  output logic [31:0] rx_data,
  output logic        spi_sclk,
  output logic        spi_mosi
);

  localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(SCLK_HALF - 1);

  logic              active_q, active_d;
  logic              high_q, high_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [6:0]        bit_idx_q, bit_idx_d;
  logic [6:0]        bit_count_q, bit_count_d;
  logic [63:0]       tx_q, tx_d;
  logic [30:0]       rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              half_last, last_bit;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    active_d    = active_q;
    high_d      = high_q;
    half_cnt_d  = half_cnt_q;
    bit_idx_d   = bit_idx_q;
    bit_count_d = bit_count_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;

    half_last = (half_cnt_q == HALF_MAX);
    last_bit  = (bit_idx_q == bit_count_q - 7'd1);
    bit_end   = active_q && high_q && half_last;
    done      = bit_end && last_bit;
    // The final MISO bit is folded in combinationally so the parent sees it in the done cycle.
    rx_data   = {rx_q, spi_miso};

    if (start) begin
      active_d    = 1'b1;
      high_d      = 1'b0;
      half_cnt_d  = '0;
      bit_idx_d   = '0;
      bit_count_d = bit_count;
      sclk_d      = 1'b0;
      mosi_d      = tx_word[63];
      tx_d        = {tx_word[62:0], 1'b0};
    end else if (active_q) begin
      if (!half_last) begin
        half_cnt_d = half_cnt_q + 1'b1;
      end else begin
        half_cnt_d = '0;
        if (!high_q) begin
          high_d = 1'b1;
          sclk_d = 1'b1;
        end else begin
          high_d = 1'b0;
          sclk_d = 1'b0;
          rx_d   = rx_data[30:0];
          if (last_bit) begin
            active_d = 1'b0;
            mosi_d   = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 7'd1;
            mosi_d    = tx_q[63];
            tx_d      = {tx_q[62:0], 1'b0};
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      high_q      <= 1'b0;
      half_cnt_q  <= '0;
      bit_idx_q   <= '0;
      bit_count_q <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      active_q    <= active_d;
      high_q      <= high_d;
      half_cnt_q  <= half_cnt_d;
      bit_idx_q   <= bit_idx_d;
      bit_count_q <= bit_count_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
    end
  end

  assign bit_idx  = bit_idx_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: rtl/qspi_mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store ports that
// runs one read/write SPI transaction per grant on the flash/PSRAM bus.
module qspi_mem_arbiter
  import soc_pkg::*;
#(
  parameter int SCLK_HALF     = 1,
  parameter int CS_GAP        = 2,
  parameter int PSRAM_SEL_BIT = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [24:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [24:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_flash_n,
  output logic        spi_cs_ram_n
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CS_GAP - 1);

  state_e      state_q, state_d;
  xfer_ctx_t   ctx_q, ctx_d, sel_ctx;
  logic        prefer_d_q, prefer_d_d;
  logic        cs_flash_n_q, cs_flash_n_d, cs_ram_n_q, cs_ram_n_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d, d_valid_q, d_valid_d, d_err_q, d_err_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic        if_pend, d_pend, grant_if, grant_d, sel_we, sel_ram;
  logic [24:0] sel_addr;
  logic [63:0] tx_word;
  logic [6:0]  bit_count, bit_idx;
  logic        start, bit_end, done;
  logic [31:0] rx_data, rd_word;

  spi_shifter #(.SCLK_HALF(SCLK_HALF)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx_word   (tx_word),
    .bit_count (bit_count),
    .spi_miso  (spi_miso),
    .bit_idx   (bit_idx),
    .bit_end   (bit_end),
    .done      (done),
    .rx_data   (rx_data),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi)
  );

  always_comb begin
    // A port whose valid is high this cycle is still holding its old request.
    if_pend  = if_req && !if_valid_q;
    d_pend   = d_req && !d_valid_q;
    grant_d  = d_pend && (!if_pend || prefer_d_q);
    grant_if = if_pend && !grant_d;

    sel_addr         = grant_if ? if_addr : d_addr;
    sel_we           = grant_d && d_we;
    sel_ram          = sel_addr[PSRAM_SEL_BIT];
    sel_ctx.is_fetch = grant_if;
    sel_ctx.size     = grant_if ? SIZE_WORD : size_e'(d_size);
    tx_word   = {sel_we ? SPI_CMD_WRITE : SPI_CMD_READ, sel_addr[23:0],
                 sel_we ? bswap32(d_wdata) : 32'h0};
    bit_count = xfer_bits(sel_ctx.size);

    // Data arrives byte 0 first, so the last byte shifted in is the highest one.
    case (ctx_q.size)
      SIZE_BYTE: rd_word = {24'h0, rx_data[7:0]};
      SIZE_HALF: rd_word = {16'h0, rx_data[7:0], rx_data[15:8]};
      default:   rd_word = bswap32(rx_data);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ctx_d        = ctx_q;
    prefer_d_d   = prefer_d_q;
    cs_flash_n_d = cs_flash_n_q;
    cs_ram_n_d   = cs_ram_n_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    gap_cnt_d    = gap_cnt_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    d_err_d      = 1'b0;
    start        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_if || grant_d) begin
          ctx_d      = sel_ctx;
          prefer_d_d = grant_if;
          if (sel_we && !sel_ram) begin
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
          end else begin
            start        = 1'b1;
            state_d      = ST_CMD;
            cs_flash_n_d = sel_ram;
            cs_ram_n_d   = !sel_ram;
          end
        end
      end
      ST_CMD:  if (bit_end && bit_idx == 7'd7)  state_d = ST_ADDR;
      ST_ADDR: if (bit_end && bit_idx == 7'd31) state_d = ST_DATA;
      ST_DATA: begin
        if (done) begin
          state_d      = ST_DONE;
          cs_flash_n_d = 1'b1;
          cs_ram_n_d   = 1'b1;
          if (ctx_q.is_fetch) begin
            if_valid_d = 1'b1;
            if_rdata_d = rd_word;
          end else begin
            d_valid_d = 1'b1;
            if (!d_we) d_rdata_d = rd_word;
          end
        end
      end
      ST_DONE: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_MAX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ctx_q        <= '0;
      prefer_d_q   <= 1'b0;
      cs_flash_n_q <= 1'b1;
      cs_ram_n_q   <= 1'b1;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      d_err_q      <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ctx_q        <= ctx_d;
      prefer_d_q   <= prefer_d_d;
      cs_flash_n_q <= cs_flash_n_d;
      cs_ram_n_q   <= cs_ram_n_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      d_err_q      <= d_err_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign if_rdata       = if_rdata_q;
  assign if_valid       = if_valid_q;
  assign d_rdata        = d_rdata_q;
  assign d_valid        = d_valid_q;
  assign d_err          = d_err_q;
  assign spi_cs_flash_n = cs_flash_n_q;
  assign spi_cs_ram_n   = cs_ram_n_q;

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Directed bench for qspi_mem_arbiter with a small SPI slave model that
// records MOSI and plays back scripted MISO bytes.
module tb_qspi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [24:0] if_addr, d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_valid, d_valid, d_err;
  logic        spi_sclk, spi_mosi, spi_cs_flash_n, spi_cs_ram_n;
  logic        spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  qspi_mem_arbiter #(.SCLK_HALF(1), .CS_GAP(2), .PSRAM_SEL_BIT(24)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_rdata       (if_rdata),
    .if_valid       (if_valid),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_size         (d_size),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_valid        (d_valid),
    .d_err          (d_err),
    .spi_sclk       (spi_sclk),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .spi_cs_flash_n (spi_cs_flash_n),
    .spi_cs_ram_n   (spi_cs_ram_n)
  );

  always #5 clk = ~clk;

  // Slave model: byte i of resp is returned in the data phase, MSB first.
  logic [7:0]  resp [4];
  logic [63:0] mon_mosi = '0;
  int          mon_bits = 0;
  wire         cs_any_n = spi_cs_flash_n & spi_cs_ram_n;

  function automatic logic miso_bit(input int i);
    int k;
    logic [7:0] b;
    if (i < 32) return 1'b0;
    k = i - 32;
    b = resp[k / 8];
    return b[7 - (k % 8)];
  endfunction

  always @(posedge spi_sclk or posedge cs_any_n) begin
    if (cs_any_n) begin
      mon_bits <= 0;
    end else begin
      mon_mosi <= {mon_mosi[62:0], spi_mosi};
      spi_miso <= miso_bit(mon_bits);
      mon_bits <= mon_bits + 1;
    end
  end

  // Issues one request in cycle T and measures cs/valid timing relative to T.
  task automatic run_txn(input bit fetch, output int first_low, output int flash_low,
                         output int ram_low, output int valid_at,
                         output logic [31:0] rdata, output logic err);
    first_low = -1; flash_low = 0; ram_low = 0; valid_at = -1; rdata = '0; err = 1'b0;
    repeat (5) @(negedge clk);
    if (fetch) if_req = 1'b1;
    else d_req = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (!spi_cs_flash_n) flash_low++;
      if (!spi_cs_ram_n) ram_low++;
      if ((!spi_cs_flash_n || !spi_cs_ram_n) && first_low < 0) first_low = n;
      if (fetch ? if_valid : d_valid) begin
        valid_at = n;
        rdata    = fetch ? if_rdata : d_rdata;
        err      = fetch ? 1'b0 : d_err;
        break;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  task automatic test_reset();
    checks += 9;
    if (spi_cs_flash_n !== 1'b1) begin errors++; $display("FAIL reset_cs_flash: got %b want 1", spi_cs_flash_n); end
    if (spi_cs_ram_n !== 1'b1) begin errors++; $display("FAIL reset_cs_ram: got %b want 1", spi_cs_ram_n); end
    if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
    if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
    if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b want 0", d_valid); end
    if (d_err !== 1'b0) begin errors++; $display("FAIL reset_d_err: got %b want 0", d_err); end
    if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
    if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
  endtask

  task automatic test_round_robin();
    int order [$];
    bit if_done, d_done, seen_low, both_valid;
    int run, min_gap, n_gaps;
    int exp_order [6] = '{0, 1, 0, 1, 0, 1};
    seen_low = 0; both_valid = 0; run = 0; min_gap = 1000; n_gaps = 0;
    if_addr = 25'h0000040; d_addr = 25'h1000008; d_we = 1'b0; d_size = 2'd0;
    resp[0] = 8'h5A; resp[1] = 8'h00; resp[2] = 8'h00; resp[3] = 8'h00;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1;
      if_done = 0; d_done = 0;
      for (int n = 0; n < 600 && !(if_done && d_done); n++) begin
        @(negedge clk);
        if (if_valid && d_valid) both_valid = 1;
        if (spi_cs_flash_n && spi_cs_ram_n) run++;
        else begin
          if (seen_low && run > 0) begin
            n_gaps++;
            if (run < min_gap) min_gap = run;
          end
          run = 0; seen_low = 1;
        end
        if (if_valid) begin order.push_back(0); if_req = 1'b0; if_done = 1; end
        if (d_valid) begin order.push_back(1); d_req = 1'b0; d_done = 1; end
      end
      if_req = 1'b0; d_req = 1'b0;
    end
    checks++;
    if (order.size() != 6) begin errors++; $display("FAIL rr_count: got %0d completions want 6", order.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= order.size() || order[i] != exp_order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d want %0d (0=fetch 1=data)", i, (i < order.size()) ? order[i] : -1, exp_order[i]);
      end
    end
    checks++;
    if (n_gaps != 5 || min_gap < 2) begin errors++; $display("FAIL rr_cs_gap: got %0d gaps min %0d want 5 gaps min >=2", n_gaps, min_gap); end
    checks++;
    if (both_valid) begin errors++; $display("FAIL rr_valid_overlap: got both valids high want never"); end
  endtask

  task automatic test_fetch_read();
    int fl, fcnt, rcnt, va;
    logic [31:0] rd;
    logic er;
    if_addr = 25'h0000010;
    resp[0] = 8'h13; resp[1] = 8'h00; resp[2] = 8'h00; resp[3] = 8'h6F;
    run_txn(1'b1, fl, fcnt, rcnt, va, rd, er);
    checks += 6;
    if (mon_mosi[63:32] !== 32'h03000010) begin errors++; $display("FAIL fetch_mosi: got %h want 03000010", mon_mosi[63:32]); end
    if (fl != 1) begin errors++; $display("FAIL fetch_cs_start: got T+%0d want T+1", fl); end
    if (fcnt != 128) begin errors++; $display("FAIL fetch_cs_flash_low: got %0d want 128", fcnt); end
    if (rcnt != 0) begin errors++; $display("FAIL fetch_cs_ram_low: got %0d want 0", rcnt); end
    if (va != 129) begin errors++; $display("FAIL fetch_valid_time: got T+%0d want T+129", va); end
    if (rd !== 32'h6F000013) begin errors++; $display("FAIL fetch_rdata: got %h want 6f000013", rd); end
  endtask

  task automatic test_psram_write();
    int fl, fcnt, rcnt, va;
    logic [31:0] rd;
    logic er;
    d_addr = 25'h1000004; d_we = 1'b1; d_size = 2'd0; d_wdata = 32'h000000AB;
    run_txn(1'b0, fl, fcnt, rcnt, va, rd, er);
    checks += 5;
    if (mon_mosi[39:0] !== 40'h02000004AB) begin errors++; $display("FAIL pwr_mosi: got %h want 02000004ab", mon_mosi[39:0]); end
    if (rcnt != 80) begin errors++; $display("FAIL pwr_cs_ram_low: got %0d want 80", rcnt); end
    if (fcnt != 0) begin errors++; $display("FAIL pwr_cs_flash_low: got %0d want 0", fcnt); end
    if (va != 81) begin errors++; $display("FAIL pwr_valid_time: got T+%0d want T+81", va); end
    if (er !== 1'b0) begin errors++; $display("FAIL pwr_err: got %b want 0", er); end
  endtask

  task automatic test_flash_write();
    int fl, fcnt, rcnt, va;
    logic [31:0] rd;
    logic er;
    bit extra;
    d_addr = 25'h0000100; d_we = 1'b1; d_size = 2'd2; d_wdata = 32'hDEADBEEF;
    run_txn(1'b0, fl, fcnt, rcnt, va, rd, er);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (!spi_cs_flash_n || !spi_cs_ram_n || d_valid) extra = 1;
    end
    checks += 5;
    if (va != 1) begin errors++; $display("FAIL fwr_valid_time: got T+%0d want T+1", va); end
    if (er !== 1'b1) begin errors++; $display("FAIL fwr_err: got %b want 1", er); end
    if (fcnt != 0) begin errors++; $display("FAIL fwr_cs_flash_low: got %0d want 0", fcnt); end
    if (rcnt != 0) begin errors++; $display("FAIL fwr_cs_ram_low: got %0d want 0", rcnt); end
    if (extra) begin errors++; $display("FAIL fwr_quiet_after: got bus/valid activity want none"); end
  endtask

  task automatic test_psram_read_half();
    int fl, fcnt, rcnt, va;
    logic [31:0] rd;
    logic er;
    d_addr = 25'h1000020; d_we = 1'b0; d_size = 2'd1;
    resp[0] = 8'h34; resp[1] = 8'h12; resp[2] = 8'hFF; resp[3] = 8'hFF;
    run_txn(1'b0, fl, fcnt, rcnt, va, rd, er);
    checks += 5;
    if (mon_mosi[47:16] !== 32'h03000020) begin errors++; $display("FAIL prd_mosi: got %h want 03000020", mon_mosi[47:16]); end
    if (rcnt != 96) begin errors++; $display("FAIL prd_cs_ram_low: got %0d want 96", rcnt); end
    if (va != 97) begin errors++; $display("FAIL prd_valid_time: got T+%0d want T+97", va); end
    if (rd !== 32'h00001234) begin errors++; $display("FAIL prd_rdata: got %h want 00001234", rd); end
    if (er !== 1'b0) begin errors++; $display("FAIL prd_err: got %b want 0", er); end
  endtask

  task automatic test_reset_mid();
    int fl, fcnt, rcnt, va, waited;
    logic [31:0] rd;
    logic er;
    bit got_valid;
    if_addr = 25'h0000010;
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33; resp[3] = 8'h44;
    repeat (5) @(negedge clk);
    if_req = 1'b1;
    waited = 0;
    while (mon_bits < 20 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (mon_bits < 20) begin errors++; $display("FAIL rst_mid_reach_bit20: got %0d bits want 20", mon_bits); end
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (spi_cs_flash_n !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_async: got %b want 1", spi_cs_flash_n); end
    if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk: got %b want 0", spi_sclk); end
    if_req = 1'b0;
    got_valid = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_valid) got_valid = 1;
    end
    rst_n = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (if_valid || !spi_cs_flash_n) got_valid = 1;
    end
    checks++;
    if (got_valid) begin errors++; $display("FAIL rst_mid_no_valid: got valid or bus activity after abort want none"); end
    run_txn(1'b1, fl, fcnt, rcnt, va, rd, er);
    checks += 3;
    if (va != 129) begin errors++; $display("FAIL rst_mid_refetch_time: got T+%0d want T+129", va); end
    if (fcnt != 128) begin errors++; $display("FAIL rst_mid_refetch_cs: got %0d want 128", fcnt); end
    if (rd !== 32'h44332211) begin errors++; $display("FAIL rst_mid_refetch_rdata: got %h want 44332211", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'd0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00; resp[3] = 8'h00;
    #23;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_round_robin();
    test_fetch_read();
    test_psram_write();
    test_flash_write();
    test_psram_read_half();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
